alu_seq: RTL
============

# alu_seq

Parametrised, handshaked successor to the datapath ALU. Results and flags are registered; the block adds signed overflow, subtract, and multi-cycle iterative shifts. An optional shift-add multiplier is available behind a macro. It sits between the register-file read stage and write-back, and the control unit drives it through a valid/ready pair on each side.

## Interface
- WIDTH, 32: datapath width; power of two, 8..64.
- SW, $clog2(WIDTH): shift-amount width (derived, do not override).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operation request.
- in_ready  out  1  block can accept; high only in IDLE and reset low.
- op  in  4  operation code (see Operation).
- x  in  WIDTH  operand A.
- y  in  WIDTH  operand B; y[SW-1:0] is shift amount for shifts.
- out_valid  out  1  result/flags valid.
- out_ready  in  1  consumer takes result.
- value  out  WIDTH  result.
- carry  out  1  carry / no-borrow / last bit shifted out / mul high-half-nonzero.
- zeroflag  out  1  value == 0.
- msb  out  1  value[WIDTH-1].
- overflow  out  1  signed overflow (ADD/SUB only, else 0).
- illegal  out  1  op not implemented in this build.

## Operation
- Ops:
  - 0 ADD x+y.
  - 1 SUB x+~y+1 (carry=1 means no borrow).
  - 2 INC x+1.
  - 3 AND.
  - 4 OR.
  - 5 XOR.
  - 6 NOR.
  - 7 NOT x.
  - 8 SLL.
  - 9 SRL.
  - 10 SRA.
  - 11 MUL (macro only).
  - 12..15 illegal.
- Arithmetic at WIDTH+1 bits; value = low WIDTH bits, carry = bit WIDTH.
- overflow: ADD = (x[msb]==y[msb]) && value[msb]!=x[msb]. SUB = (x[msb]!=y[msb]) && value[msb]!=x[msb].
- Logic ops (3..7): carry=0, overflow=0.
- Illegal op: value=0, carry=0, overflow=0, zeroflag=1, msb=0, illegal=1; completes as single-cycle op.
- FSM states: IDLE, SHIFT, MUL, DONE.
  - IDLE: on in_valid&&in_ready, latch op/x/y. Ops 0..7, illegal ops, and shifts with amount 0 load the result regs and go to DONE. Shifts with amount n>0 load counter=n and go to SHIFT. MUL goes to MUL with counter=WIDTH.
  - SHIFT: shift working reg one bit per cycle (SRA replicates sign); carry = bit shifted out. Counter decrements; at counter==1 the final shift is applied, then DONE.
  - MUL: one shift-add step per cycle on a 2*WIDTH accumulator; after WIDTH steps, value = low half and carry = |high half; then DONE.
  - DONE: out_valid=1; value and flags held stable until out_ready; on out_ready go to IDLE.
- zeroflag/msb derived from the final registered value; stable while out_valid.
- Operands are sampled only at acceptance; x/y changes afterwards are ignored.
- Shift by zero: value=x, carry=0.

## Timing
- Reset, any state: next state IDLE, counter 0, value=0, carry=0, zeroflag=0, msb=0, overflow=0, illegal=0, out_valid=0. in_ready=0 while reset high, 1 first cycle after.
- Reset mid-SHIFT/MUL/DONE: operation discarded, no out_valid.
- Acceptance at edge E. out_valid rises after:
  - single-cycle ops: E+1.
  - shift by n: E+1+n.
  - MUL: E+1+WIDTH.
- Shift by 0: same as single-cycle.
- Release at the edge where out_valid&&out_ready; in_ready high the next cycle.
- No overlap: in_ready=0 in SHIFT/MUL/DONE. Minimum issue interval is 2 cycles (single-cycle op, out_ready held high).
- in_valid while not ready: ignored, no effect; the producer must hold the request.

## Configuration
- ALU_SEQ_MUL_EN defined: op 11 is a WIDTH-cycle unsigned shift-add multiply; MUL state and 2*WIDTH accumulator built.
- Not defined: no MUL state or accumulator; op 11 treated as illegal (illegal=1, single-cycle).

## Test plan
- Reset then ADD, WIDTH=32, x=0xFFFFFFFF, y=1 -> value 0, carry 1, zeroflag 1, overflow 0, out_valid 2nd cycle after acceptance.
- ADD x=0x7FFFFFFF, y=1 -> value 0x80000000, overflow 1, msb 1. SUB x=3, y=5 -> value 0xFFFFFFFE, carry 0.
- SRA x=0x80000010, y=4 -> value 0xF8000001, carry 0, out_valid exactly 5 cycles after acceptance. SLL shift 0 -> value=x, 1-cycle latency.
- Backpressure: hold out_ready=0 for 10 cycles in DONE -> value/flags stable, in_ready 0, a new in_valid ignored. Then out_ready=1 -> IDLE next cycle.
- Assert reset on 3rd cycle of SLL by 20 -> no out_valid; all outputs 0; next ADD 2+3 -> value 5.
- With ALU_SEQ_MUL_EN, MUL 0x10000*0x10000 -> value 0, carry 1, latency 33. Without the macro, op 11 -> illegal 1, value 0, latency 1.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: registered result/flags, iterative shifts, optional multiply.
// Optional feature macro: ALU_SEQ_MUL_EN (builds the shift-add multiplier for op 11).
//
// state | meaning
// IDLE  | waiting for a request, in_ready high
// SHIFT | one-bit-per-cycle shift of the working value
// MUL   | one shift-add multiply step per cycle (ALU_SEQ_MUL_EN only)
// DONE  | result presented, waiting for out_ready
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] value,
  output logic             carry,
  output logic             zeroflag,
  output logic             msb,
  output logic             overflow,
  output logic             illegal
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = SW + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [1:0] S_MUL   = 2'd2;
`endif
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_INC = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_OR  = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_NOR = 4'd6;
  localparam logic [3:0] OP_NOT = 4'd7;
  localparam logic [3:0] OP_SLL = 4'd8;
  localparam logic [3:0] OP_SRL = 4'd9;
  localparam logic [3:0] OP_SRA = 4'd10;
`ifdef ALU_SEQ_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd11;
`endif

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             msb_q, msb_d;
  logic             ovf_q, ovf_d;
  logic             ill_q, ill_d;
  logic             upd_flags;

  logic [WIDTH:0]   add_sum, sub_sum, inc_sum;
  logic [SW-1:0]    shamt;

  assign add_sum = {1'b0, x} + {1'b0, y};
  assign sub_sum = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
  assign inc_sum = {1'b0, x} + {{WIDTH{1'b0}}, 1'b1};
  assign shamt   = y[SW-1:0];

`ifdef ALU_SEQ_MUL_EN
  // Multiplier sits in the low half of the accumulator and is consumed LSB first.
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH:0]     mul_sum;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
  assign acc_step = {mul_sum, acc_q[WIDTH-1:1]};
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    val_d     = val_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    msb_d     = msb_q;
    ovf_d     = ovf_q;
    ill_d     = ill_q;
    upd_flags = 1'b0;
`ifdef ALU_SEQ_MUL_EN
    acc_d     = acc_q;
    mcand_d   = mcand_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = op;
          carry_d   = 1'b0;
          ovf_d     = 1'b0;
          ill_d     = 1'b0;
          upd_flags = 1'b1;
          state_d   = S_DONE;
          case (op)
            OP_ADD: begin
              {carry_d, val_d} = add_sum;
              ovf_d = (x[WIDTH-1] == y[WIDTH-1]) && (add_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_SUB: begin
              {carry_d, val_d} = sub_sum;
              ovf_d = (x[WIDTH-1] != y[WIDTH-1]) && (sub_sum[WIDTH-1] != x[WIDTH-1]);
            end
            OP_INC: {carry_d, val_d} = inc_sum;
            OP_AND: val_d = x & y;
            OP_OR:  val_d = x | y;
            OP_XOR: val_d = x ^ y;
            OP_NOR: val_d = ~(x | y);
            OP_NOT: val_d = ~x;
            OP_SLL, OP_SRL, OP_SRA: begin
              val_d = x;
              if (shamt != '0) begin
                cnt_d   = {1'b0, shamt};
                state_d = S_SHIFT;
              end
            end
`ifdef ALU_SEQ_MUL_EN
            OP_MUL: begin
              upd_flags = 1'b0;
              acc_d     = {{WIDTH{1'b0}}, y};
              mcand_d   = x;
              cnt_d     = CW'(WIDTH);
              state_d   = S_MUL;
            end
`endif
            default: begin
              val_d = '0;
              ill_d = 1'b1;
            end
          endcase
        end
      end
      S_SHIFT: begin
        upd_flags = 1'b1;
        if (op_q == OP_SLL) begin
          val_d   = {val_q[WIDTH-2:0], 1'b0};
          carry_d = val_q[WIDTH-1];
        end else if (op_q == OP_SRL) begin
          val_d   = {1'b0, val_q[WIDTH-1:1]};
          carry_d = val_q[0];
        end else begin
          val_d   = {val_q[WIDTH-1], val_q[WIDTH-1:1]};
          carry_d = val_q[0];
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = S_DONE;
      end
`ifdef ALU_SEQ_MUL_EN
      S_MUL: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          val_d     = acc_step[WIDTH-1:0];
          carry_d   = |acc_step[2*WIDTH-1:WIDTH];
          upd_flags = 1'b1;
          state_d   = S_DONE;
        end
      end
`endif
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (upd_flags) begin
      zero_d = (val_d == '0);
      msb_d  = val_d[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      val_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      msb_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ill_q   <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= '0;
      mcand_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      val_q   <= val_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      msb_q   <= msb_d;
      ovf_q   <= ovf_d;
      ill_q   <= ill_d;
`ifdef ALU_SEQ_MUL_EN
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE) && !reset;
  assign out_valid = (state_q == S_DONE);
  assign value     = val_q;
  assign carry     = carry_q;
  assign zeroflag  = zero_q;
  assign msb       = msb_q;
  assign overflow  = ovf_q;
  assign illegal   = ill_q;
endmodule
